// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: FSM state encodings,
// bit positions inside the `functions` mode field and the default width.
package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT = 16;

  typedef logic [0:0] pwm_state_t;
  localparam pwm_state_t ST_IDLE = 1'b0;
  localparam pwm_state_t ST_RUN  = 1'b1;

  localparam int FN_ALIGN  = 0;
  localparam int FN_RANGE  = 1;
  localparam int FN_INVERT = 2;

endpackage

// File: rtl/pwm_boundary_detect.sv
// Flags the first sample of a new counter period; a value held across
// prescaler stalls is only reported once because it must differ from the last.
module pwm_boundary_detect #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_val,
  input  logic [WIDTH-1:0] period,
  input  logic             upnotdown,
  output logic             wrap
);

  logic [WIDTH-1:0] prev_cnt_q;
  logic [WIDTH-1:0] prev_cnt_d;
  logic             at_edge;

  always_comb begin
    prev_cnt_d = count_val;
    at_edge    = upnotdown ? (count_val == '0) : (count_val == period);
    wrap       = at_edge && (count_val != prev_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_cnt_q <= '0;
    else        prev_cnt_q <= prev_cnt_d;
  end

endmodule

// File: rtl/pwm_output_stage.sv
// PWM pin driver: compares the timebase count against compare values that are
// double-buffered to period boundaries, and strobes period_done on each boundary.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_val,
  input  logic [WIDTH-1:0] period,
  input  logic             upnotdown,
  input  logic             pwm_en,
  input  logic [WIDTH-1:0] compare1,
  input  logic [WIDTH-1:0] compare2,
  input  logic [2:0]       functions,
  output logic             pwm_out,
  output logic             period_done
);

  pwm_state_t       state_q, state_d;
  logic [WIDTH-1:0] cmp1_sh_q, cmp1_sh_d;
  logic [WIDTH-1:0] cmp2_sh_q, cmp2_sh_d;
  logic [2:0]       func_sh_q, func_sh_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_done_q, period_done_d;

  logic             wrap;
  logic             load_sh;
  logic             run_act;
  logic             raw;
  logic [WIDTH-1:0] cmp1_eff, cmp2_eff;
  logic [2:0]       func_eff;

  pwm_boundary_detect #(.WIDTH(WIDTH)) u_boundary (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_val (count_val),
    .period    (period),
    .upnotdown (upnotdown),
    .wrap      (wrap)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && pwm_en)      state_d = ST_RUN;
    else if (state_q == ST_RUN && !pwm_en) state_d = ST_IDLE;

    // Shadows track the register side while idle so RUN starts on fresh values.
    load_sh   = (state_q == ST_IDLE) || wrap;
    cmp1_sh_d = load_sh ? compare1  : cmp1_sh_q;
    cmp2_sh_d = load_sh ? compare2  : cmp2_sh_q;
    func_sh_d = load_sh ? functions : func_sh_q;

    // The boundary sample itself already belongs to the new period.
    cmp1_eff = wrap ? compare1  : cmp1_sh_q;
    cmp2_eff = wrap ? compare2  : cmp2_sh_q;
    func_eff = wrap ? functions : func_sh_q;

    raw = 1'b0;
    if (func_eff[FN_RANGE]) begin
      if (cmp1_eff >= cmp2_eff) raw = 1'b0;
      else                      raw = (count_val >= cmp1_eff) && (count_val < cmp2_eff);
    end else if (func_eff[FN_ALIGN]) begin
      if (cmp1_eff == '0) raw = 1'b1;
      else                raw = (count_val >= cmp1_eff);
    end else begin
      if (cmp1_eff == '0)          raw = 1'b0;
      else if (cmp1_eff > period)  raw = 1'b1;
      else                         raw = (count_val < cmp1_eff);
    end

    // Gating on pwm_en lets a disable force the pin low on the very next edge.
    run_act       = (state_q == ST_RUN) && pwm_en;
    pwm_out_d     = run_act && (raw ^ func_eff[FN_INVERT]);
    period_done_d = run_act && wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmp1_sh_q     <= '0;
      cmp2_sh_q     <= '0;
      func_sh_q     <= '0;
      pwm_out_q     <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmp1_sh_q     <= cmp1_sh_d;
      cmp2_sh_q     <= cmp2_sh_d;
      func_sh_q     <= func_sh_d;
      pwm_out_q     <= pwm_out_d;
      period_done_q <= period_done_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage: the counter is driven directly by the
// bench, one value per call of apply(), outputs sampled 1 time unit after the edge.
module tb_pwm_output_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] count_val;
  logic [15:0] period;
  logic        upnotdown;
  logic        pwm_en;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [2:0]  functions;
  logic        pwm_out;
  logic        period_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_output_stage #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_val   (count_val),
    .period      (period),
    .upnotdown   (upnotdown),
    .pwm_en      (pwm_en),
    .compare1    (compare1),
    .compare2    (compare2),
    .functions   (functions),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  task automatic apply(input logic [15:0] c);
    @(negedge clk);
    count_val = c;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] fn, input logic [15:0] c1, input logic [15:0] c2);
    pwm_en    = 1'b0;
    functions = fn;
    compare1  = c1;
    compare2  = c2;
    period    = 16'd9;
    upnotdown = 1'b1;
    apply(16'd0);
    apply(16'd0);
    pwm_en = 1'b1;
    apply(16'd0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pwm_en = 1'b0; count_val = '0; period = 16'd9; upnotdown = 1'b1;
    compare1 = '0; compare2 = '0; functions = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm_out: got %b expected 0", pwm_out); end
    checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL reset_period_done: got %b expected 0", period_done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_left;
    logic [15:0] c; logic exp;
    start(3'b000, 16'd3, 16'd0);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL left_enter: got %b expected 0", pwm_out); end
    for (int k = 1; k < 21; k++) begin
      c = 16'(k % 10);
      apply(c);
      exp = (c < 16'd3);
      checks++; if (pwm_out !== exp) begin errors++; $display("FAIL left_out c=%0d: got %b expected %b", c, pwm_out, exp); end
      checks++; if (period_done !== (c == 16'd0)) begin errors++; $display("FAIL left_pd c=%0d: got %b expected %b", c, period_done, (c == 16'd0)); end
    end
  endtask

  task automatic test_right_invert;
    logic [15:0] c; logic exp;
    start(3'b101, 16'd7, 16'd0);
    for (int k = 1; k < 20; k++) begin
      c = 16'(k % 10);
      apply(c);
      exp = (c <= 16'd6);
      checks++; if (pwm_out !== exp) begin errors++; $display("FAIL right_inv c=%0d: got %b expected %b", c, pwm_out, exp); end
    end
  endtask

  task automatic test_range;
    logic [15:0] c; logic exp;
    start(3'b010, 16'd2, 16'd6);
    for (int k = 1; k < 20; k++) begin
      c = 16'(k % 10);
      if (k == 5) begin compare1 = 16'd6; compare2 = 16'd2; end
      apply(c);
      exp = (k < 10) ? (c >= 16'd2 && c <= 16'd5) : 1'b0;
      checks++; if (pwm_out !== exp) begin errors++; $display("FAIL range k=%0d c=%0d: got %b expected %b", k, c, pwm_out, exp); end
    end
  endtask

  task automatic test_buffered_write;
    logic [15:0] c; logic exp;
    start(3'b000, 16'd3, 16'd0);
    for (int k = 1; k < 30; k++) begin
      c = 16'(k % 10);
      if (k == 5)  compare1 = 16'd8;
      if (k == 20) compare1 = 16'd2;
      apply(c);
      if (k < 10)      exp = (c < 16'd3);
      else if (k < 20) exp = (c < 16'd8);
      else             exp = (c < 16'd2);
      checks++; if (pwm_out !== exp) begin errors++; $display("FAIL buffered k=%0d c=%0d: got %b expected %b", k, c, pwm_out, exp); end
    end
  endtask

  task automatic test_down;
    logic [15:0] c; logic exp;
    pwm_en = 1'b0; functions = 3'b000; compare1 = 16'd3; period = 16'd9; upnotdown = 1'b0;
    apply(16'd9); apply(16'd9);
    pwm_en = 1'b1;
    apply(16'd9);
    for (int k = 1; k < 20; k++) begin
      c = 16'(9 - (k % 10));
      apply(c);
      exp = (c < 16'd3);
      checks++; if (pwm_out !== exp) begin errors++; $display("FAIL down_out c=%0d: got %b expected %b", c, pwm_out, exp); end
      checks++; if (period_done !== (c == 16'd9)) begin errors++; $display("FAIL down_pd c=%0d: got %b expected %b", c, period_done, (c == 16'd9)); end
    end
  endtask

  task automatic test_prescale;
    logic [15:0] c; logic exp_pd; int pd_cnt;
    pd_cnt = 0;
    start(3'b000, 16'd3, 16'd0);
    for (int k = 1; k < 21; k++) begin
      c = 16'(k % 10);
      for (int r = 0; r < 4; r++) begin
        apply(c);
        exp_pd = (c == 16'd0) && (r == 0);
        if (period_done === 1'b1) pd_cnt++;
        checks++; if (pwm_out !== (c < 16'd3)) begin errors++; $display("FAIL prescale_out c=%0d r=%0d: got %b expected %b", c, r, pwm_out, (c < 16'd3)); end
        checks++; if (period_done !== exp_pd) begin errors++; $display("FAIL prescale_pd c=%0d r=%0d: got %b expected %b", c, r, period_done, exp_pd); end
      end
    end
    checks++; if (pd_cnt != 2) begin errors++; $display("FAIL prescale_pd_total: got %0d expected 2", pd_cnt); end
  endtask

  task automatic test_disable;
    start(3'b000, 16'd3, 16'd0);
    apply(16'd1);
    checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL disable_pre: got %b expected 1", pwm_out); end
    pwm_en = 1'b0;
    apply(16'd2);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL disable_out: got %b expected 0", pwm_out); end
    apply(16'd0);
    checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL disable_pd: got %b expected 0", period_done); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL disable_idle_out: got %b expected 0", pwm_out); end
  endtask

  task automatic test_reset_mid;
    start(3'b000, 16'd3, 16'd0);
    for (int k = 1; k < 10; k++) apply(16'(k));
    apply(16'd0);
    checks++; if (pwm_out !== 1'b1 || period_done !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got out=%b pd=%b expected 1 1", pwm_out, period_done); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rstmid_out: got %b expected 0", pwm_out); end
    checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL rstmid_pd: got %b expected 0", period_done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_edges;
    logic [15:0] c;
    start(3'b000, 16'd0, 16'd0);
    for (int k = 1; k < 20; k++) begin
      c = 16'(k % 10);
      apply(c);
      checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL edge_cmp0 c=%0d: got %b expected 0", c, pwm_out); end
    end
    start(3'b000, 16'd10, 16'd0);
    for (int k = 1; k < 20; k++) begin
      c = 16'(k % 10);
      apply(c);
      checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL edge_cmp10 c=%0d: got %b expected 1", c, pwm_out); end
    end
  endtask

  initial begin
    test_reset;
    test_left;
    test_right_invert;
    test_range;
    test_buffered_write;
    test_down;
    test_prescale;
    test_disable;
    test_reset_mid;
    test_edges;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
